// File: rtl/spi_multi_master.sv
// SPI master that drives NUM_SLAVES dedicated SCLK/SDI/CSB channel sets, one transaction at a time.
// Define SPI_READBACK_EN to build the MISO receive path; without it rx_data is tied to zero.
module spi_multi_master #(
    parameter int NUM_SLAVES = 5,
    parameter int DATA_W     = 16,
    parameter int DIV_W      = 8,
    localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SEL_W-1:0]      chan_sel,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rx_data,
    output logic [NUM_SLAVES-1:0] sclk,
    output logic [NUM_SLAVES-1:0] sdi,
    output logic [NUM_SLAVES-1:0] csb,
    input  logic [NUM_SLAVES-1:0] sdo
);
    localparam int ECW = $clog2(2 * DATA_W + 1);
    localparam logic [ECW-1:0]   LAST_EDGE = ECW'(2 * DATA_W - 1);
    localparam logic [SEL_W:0]   NUM_CH    = (SEL_W + 1)'(NUM_SLAVES);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [ECW-1:0]    ecnt;
    logic [SEL_W-1:0]  ch_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_sh;
    logic              tick;
    logic              odd_edge;
    logic              shift_edge;
    logic              accept;
    logic              edge_now;

    // ecnt holds the number of edges already issued, so the next edge is odd when ecnt is even
    assign tick       = (cnt == div_q);
    assign odd_edge   = ~ecnt[0];
    assign shift_edge = cpha_q ? odd_edge : ~odd_edge;
    assign accept     = (state == IDLE) && start && ({1'b0, chan_sel} < NUM_CH);
    assign edge_now   = ((state == LEAD) || (state == SHIFT)) && tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            csb    <= '1;
            sclk   <= '0;
            sdi    <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            div_q  <= '0;
            cnt    <= '0;
            ecnt   <= '0;
            ch_q   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state != IDLE)
                cnt <= tick ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= LEAD;
                        busy           <= 1'b1;
                        ch_q           <= chan_sel;
                        div_q          <= clk_div;
                        cpol_q         <= cpol;
                        cpha_q         <= cpha;
                        cnt            <= '0;
                        ecnt           <= '0;
                        csb[chan_sel]  <= 1'b0;
                        sclk           <= {NUM_SLAVES{cpol}};
                        if (!cpha)
                            sdi[chan_sel] <= tx_data[DATA_W-1];
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                LEAD, SHIFT: begin
                    if (tick) begin
                        sclk[ch_q] <= ~sclk[ch_q];
                        ecnt       <= ecnt + 1'b1;
                        if (shift_edge)
                            sdi[ch_q] <= tx_sh[DATA_W-1];
                        if (state == LEAD)
                            state <= SHIFT;
                        else if (ecnt == LAST_EDGE)
                            state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        csb[ch_q] <= 1'b1;
                        sdi[ch_q] <= 1'b0;
                        ecnt      <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // deselect lasts two half-periods; ecnt[0] marks the second one
                    if (tick) begin
                        if (ecnt[0]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            ecnt <= ecnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Transmit shift register: with CPHA=0 the MSB is already on the pin, so preload the rest
    always_ff @(posedge clk) begin
        if (accept)
            tx_sh <= cpha ? tx_data : {tx_data[DATA_W-2:0], 1'b0};
        else if (edge_now && shift_edge)
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rx_sh;

    always_ff @(posedge clk) begin
        if (edge_now && !shift_edge)
            rx_sh <= {rx_sh[DATA_W-2:0], sdo[ch_q]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_data <= '0;
        else if ((state == GAP) && tick && ecnt[0])
            rx_data <= rx_sh;
    end
`else
    logic unused_sdo;

    assign unused_sdo = ^sdo;
    assign rx_data    = '0;
`endif

endmodule

// File: tb/tb_spi_multi_master.sv
// Directed bench for spi_multi_master: frame timing, SPI modes, err, start-while-busy, reset abort.
module tb_spi_multi_master;
    localparam int NS = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  chan_sel;
    logic [15:0] tx_data;
    logic [7:0]  clk_div;
    logic        cpol;
    logic        cpha;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rx_data;
    logic [4:0]  sclk;
    logic [4:0]  sdi;
    logic [4:0]  csb;
    logic [4:0]  sdo;
    logic        tog = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    // channel 2 is looped back; the other MISO lines toggle freely
    assign sdo = {tog, tog, sdi[2], ~tog, tog};

    spi_multi_master #(.NUM_SLAVES(NS), .DATA_W(16), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .chan_sel(chan_sel), .tx_data(tx_data),
        .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .busy(busy), .done(done), .err(err),
        .rx_data(rx_data), .sclk(sclk), .sdi(sdi), .csb(csb), .sdo(sdo)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int ch, input logic [15:0] tx, input logic [7:0] div,
                        input logic pol, input logic pha, input bit repulse,
                        output int busy_n, output int csb_n, output int edge_n,
                        output int done_n, output int err_n, output int other_bad,
                        output logic [15:0] cap);
        logic prev;
        int   cyc;
        busy_n = 0; csb_n = 0; edge_n = 0; done_n = 0; err_n = 0; other_bad = 0;
        cap = '0;
        prev = pol;
        chan_sel = ch[2:0]; tx_data = tx; clk_div = div; cpol = pol; cpha = pha;
        start = 1'b1;
        cyc = 0;
        while (cyc < 12000 && done_n == 0) begin
            @(negedge clk);
            cyc++;
            start = repulse && (cyc == 5 || cyc == 20);
            if (repulse && cyc == 20) chan_sel = 3'd7;
            if (busy) busy_n++;
            if (done) done_n++;
            if (err) err_n++;
            if (!csb[ch]) csb_n++;
            if (sclk[ch] != prev) begin
                edge_n++;
                if ((sclk[ch] != pol) == !pha) cap = {cap[14:0], sdi[ch]};
            end
            prev = sclk[ch];
            for (int j = 0; j < NS; j++)
                if (j != ch && (csb[j] !== 1'b1 || sclk[j] !== pol || sdi[j] !== 1'b0))
                    other_bad++;
        end
        start = 1'b0;
    endtask

    int          b_n, c_n, e_n, d_n, r_n, o_n;
    logic [15:0] cap;
    logic        pol_m;
    logic        pha_m;
    logic [15:0] exp_rx;
    int          late_done;

    initial begin
        rst = 1'b1; start = 1'b0; chan_sel = '0; tx_data = '0; clk_div = '0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_csb", csb, 5'h1f);
        check_val("rst_sclk", sclk, 5'h00);
        check_val("rst_sdi", sdi, 5'h00);
        check_val("rst_rx", rx_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // mode 0, fastest clock, channel 1
        xfer(1, 16'hA5C3, 8'd0, 1'b0, 1'b0, 1'b0, b_n, c_n, e_n, d_n, r_n, o_n, cap);
        check_val("t1_busy_cycles", b_n, 35);
        check_val("t1_csb_low", c_n, 33);
        check_val("t1_edges", e_n, 32);
        check_val("t1_done", d_n, 1);
        check_val("t1_err", r_n, 0);
        check_val("t1_other_idle", o_n, 0);
        check_val("t1_sdi_frame", cap, 16'hA5C3);
`ifndef SPI_READBACK_EN
        check_val("t6_rx_zero", rx_data, 0);
`endif
        @(negedge clk);
        check_val("t1_post_busy", busy, 0);
        check_val("t1_post_done", done, 0);
        check_val("t1_post_sclk", sclk, 5'h00);

        // loopback on channel 2 across all four modes, H=4
`ifdef SPI_READBACK_EN
        exp_rx = 16'h1234;
`else
        exp_rx = 16'h0000;
`endif
        for (int m = 0; m < 4; m++) begin
            pol_m = m[1];
            pha_m = m[0];
            xfer(2, 16'h1234, 8'd3, pol_m, pha_m, 1'b0, b_n, c_n, e_n, d_n, r_n, o_n, cap);
            check_val($sformatf("t2_m%0d_busy", m), b_n, 140);
            check_val($sformatf("t2_m%0d_csb", m), c_n, 132);
            check_val($sformatf("t2_m%0d_edges", m), e_n, 32);
            check_val($sformatf("t2_m%0d_sdi", m), cap, 16'h1234);
            check_val($sformatf("t2_m%0d_other", m), o_n, 0);
            check_val($sformatf("t2_m%0d_rx", m), rx_data, exp_rx);
            @(negedge clk);
            check_val($sformatf("t2_m%0d_idle_sclk", m), sclk, {5{pol_m}});
        end

        // invalid channel indices
        for (int k = 5; k < 8; k += 2) begin
            chan_sel = 3'(k); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_val($sformatf("t3_err_%0d", k), err, 1);
            check_val($sformatf("t3_busy_%0d", k), busy, 0);
            check_val($sformatf("t3_csb_%0d", k), csb, 5'h1f);
            check_val($sformatf("t3_sclk_%0d", k), sclk, 5'h1f);
            @(negedge clk);
            check_val($sformatf("t3_err_clr_%0d", k), err, 0);
            check_val($sformatf("t3_sclk2_%0d", k), sclk, 5'h1f);
        end

        // start pulses during a transfer are dropped
        xfer(1, 16'h3C5A, 8'd0, 1'b0, 1'b0, 1'b1, b_n, c_n, e_n, d_n, r_n, o_n, cap);
        check_val("t4_busy", b_n, 35);
        check_val("t4_done", d_n, 1);
        check_val("t4_err", r_n, 0);
        check_val("t4_sdi", cap, 16'h3C5A);
        @(negedge clk);
        check_val("t4_post_busy", busy, 0);
        check_val("t4_post_done", done, 0);
        xfer(0, 16'h0F0F, 8'd0, 1'b0, 1'b1, 1'b0, b_n, c_n, e_n, d_n, r_n, o_n, cap);
        check_val("t4_next_busy", b_n, 35);
        check_val("t4_next_sdi", cap, 16'h0F0F);

        // largest half-period, H=256
        xfer(4, 16'h8001, 8'd255, 1'b1, 1'b0, 1'b0, b_n, c_n, e_n, d_n, r_n, o_n, cap);
        check_val("hmax_busy", b_n, 8960);
        check_val("hmax_csb", c_n, 8448);
        check_val("hmax_edges", e_n, 32);
        check_val("hmax_sdi", cap, 16'h8001);

        // asynchronous reset in the middle of SHIFT
        chan_sel = 3'd3; tx_data = 16'hFFFF; clk_div = 8'd1; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t5_active_csb", csb[3], 0);
        rst = 1'b1;
        #1;
        check_val("t5_csb", csb, 5'h1f);
        check_val("t5_busy", busy, 0);
        check_val("t5_sclk", sclk, 5'h00);
        check_val("t5_sdi", sdi, 5'h00);
        check_val("t5_rx", rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        check_val("t5_no_done", late_done, 0);
        xfer(3, 16'h5555, 8'd0, 1'b0, 1'b0, 1'b0, b_n, c_n, e_n, d_n, r_n, o_n, cap);
        check_val("t5_restart_busy", b_n, 35);
        check_val("t5_restart_sdi", cap, 16'h5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
